// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the FSM state encodings, the data width, the idle line level and the
// parity convention, with a helper that computes the parity bit.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  localparam int   UART_DATA_W     = 8;
  localparam logic UART_IDLE_LVL   = 1'b1;
  // Odd parity: data ones plus the parity bit add up to an odd count.
  localparam bit   UART_PARITY_ODD = 1'b1;

  function automatic logic uart_parity(input logic [UART_DATA_W-1:0] b);
    return UART_PARITY_ODD ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin arbiter.
// Searches req starting at index ptr, wrapping past N_REQ-1 to 0.
// Ports:
//   req        - request vector
//   en         - arbitration enable; no winner when low
//   ptr        - highest-priority index for this search
//   win_onehot - one-hot winner (all zero when no winner)
//   win_idx    - binary winner index (0 when no winner)
//   valid      - a winner was found
module uart_rr_arb #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             valid
);

  // One spare bit so ptr+i can exceed N_REQ-1 before the single wrap.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    valid      = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      cand = sum[IDX_W-1:0];
      if (en && !valid && req[cand]) begin
        valid            = 1'b1;
        win_idx          = cand;
        win_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler: shares one serial line among N_REQ
// requesters and sends start, 8 data bits LSB first, odd parity, stop bit(s).
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   req       - per-requester level request
//   req_data  - byte of requester i at [8i+7:8i]
//   gnt       - one-cycle one-hot pulse: byte captured
//   owner     - index of the last granted requester
//   busy      - frame on the line
//   data_tx   - registered serial output, idles high
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int CLKS_PER_BIT = 1,
  parameter  int STOP_BITS    = 1,
  localparam int IDX_W        = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*UART_DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]             gnt,
  output logic [IDX_W-1:0]             owner,
  output logic                         busy,
  output logic                         data_tx
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_e            state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic                   busy_q, busy_d;
  logic                   tx_q, tx_d;

  logic [N_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic             bit_done;

  uart_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req        (req),
    .en         (state_q == ST_IDLE),
    .ptr        (ptr_q),
    .win_onehot (arb_onehot),
    .win_idx    (arb_idx),
    .valid      (arb_valid)
  );

  assign bit_done = (timer_q == TW'(CLKS_PER_BIT - 1));

  // Outputs are registered from the next state, so the start bit, busy and
  // gnt all appear on the same edge that samples the winning request.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    tx_d    = tx_q;
    if (state_q != ST_IDLE) timer_d = bit_done ? '0 : timer_q + TW'(1);
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          for (int i = 0; i < N_REQ; i++)
            if (arb_onehot[i]) shreg_d = req_data[i*UART_DATA_W +: UART_DATA_W];
          par_d   = uart_parity(shreg_d);
          owner_d = arb_idx;
          ptr_d   = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          gnt_d   = arb_onehot;
          state_d = ST_START;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end
      end
      ST_START: if (bit_done) begin
        state_d = ST_DATA;
        idx_d   = '0;
        tx_d    = shreg_q[0];
      end
      // The shift register's bit 0 is always the bit on the line.
      ST_DATA: if (bit_done) begin
        if (idx_q == 3'd7) begin
          state_d = ST_PARITY;
          tx_d    = par_q;
        end else begin
          idx_d   = idx_q + 3'd1;
          shreg_d = shreg_q >> 1;
          tx_d    = shreg_q[1];
        end
      end
      ST_PARITY: if (bit_done) begin
        state_d = ST_STOP;
        idx_d   = '0;
        tx_d    = UART_IDLE_LVL;
      end
      ST_STOP: if (bit_done) begin
        if (idx_q == 3'(STOP_BITS - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
        tx_d = UART_IDLE_LVL;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        tx_d    = UART_IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign data_tx = tx_q;

endmodule
